// File: rtl/via_lcd_ctrl.sv
// HD44780 LCD sequencer driving a VIA's port registers, with
// per-cycle CPU priority on the VIA bus.
module via_lcd_ctrl #(
    parameter int E_HOLD   = 4,
    parameter int POLL_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_en,
    input  logic       cpu_we,
    input  logic [3:0] cpu_rs,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       timeout,
    output logic       via_en,
    output logic       via_we,
    output logic [3:0] via_rs,
    output logic [7:0] via_din,
    input  logic [7:0] via_dout
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int WW = (E_HOLD > 1) ? $clog2(E_HOLD) : 1;

    typedef enum logic [3:0] {
        INIT, IDLE, P_DDRB, P_RW, P_EH, P_WAIT, P_RD, P_SMP, P_EL,
        W_DDRB, W_ORB, W_SET, W_EH, W_WAIT, W_EL, DONE
    } state_t;

    state_t state, nxt;

    logic [7:0]    data_q;
    logic          rs_q;
    logic          busy_q;
    logic          tmo_q;
    logic [PW-1:0] poll_cnt;
    logic [WW-1:0] wait_cnt;

    logic       seq_en;
    logic       seq_we;
    logic [3:0] seq_rs;
    logic [7:0] seq_din;
    logic       wait_last;
    logic       poll_again;
    logic [7:0] ora_lo;
    logic [7:0] ora_hi;

    assign wait_last  = int'(wait_cnt) == E_HOLD - 1;
    assign poll_again = busy_q && (int'(poll_cnt) + 1 < POLL_MAX);
    assign ora_lo     = {2'b00, rs_q, 5'b0};
    assign ora_hi     = {2'b10, rs_q, 5'b0};

    always_comb begin
        {seq_en, seq_we, seq_rs, seq_din} = '0;
        nxt = state;
        case (state)
            INIT: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd3, 8'hE0};
                nxt = IDLE;
            end
            IDLE:   if (req_valid) nxt = P_DDRB;
            P_DDRB: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd2, 8'h00};
                nxt = P_RW;
            end
            P_RW: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd1, 8'h40};
                nxt = P_EH;
            end
            P_EH: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd1, 8'hC0};
                nxt = (E_HOLD == 0) ? P_RD : P_WAIT;
            end
            P_WAIT: if (wait_last) nxt = P_RD;
            P_RD: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b10, 4'd0, 8'h00};
                nxt = P_SMP;
            end
            P_SMP:  nxt = P_EL;
            P_EL: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd1, 8'h40};
                nxt = poll_again ? P_EH : W_DDRB;
            end
            W_DDRB: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd2, 8'hFF};
                nxt = W_ORB;
            end
            W_ORB: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd0, data_q};
                nxt = W_SET;
            end
            W_SET: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd1, ora_lo};
                nxt = W_EH;
            end
            W_EH: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd1, ora_hi};
                nxt = (E_HOLD == 0) ? W_EL : W_WAIT;
            end
            W_WAIT: if (wait_last) nxt = W_EL;
            W_EL: begin
                {seq_en, seq_we, seq_rs, seq_din} = {2'b11, 4'd1, ora_lo};
                nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = INIT;
        endcase
        // a CPU cycle steals the bus; only access states hold
        if (seq_en && cpu_en) nxt = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            data_q    <= '0;
            rs_q      <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            poll_cnt  <= '0;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= nxt;
            req_ready <= nxt == IDLE;
            done      <= nxt == DONE;
            timeout   <= (nxt == DONE) && tmo_q;
            if (state == P_WAIT || state == W_WAIT)
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
            if (state == IDLE && req_valid) begin
                data_q   <= req_data;
                rs_q     <= req_rs;
                poll_cnt <= '0;
                tmo_q    <= 1'b0;
            end
            if (state == P_SMP)
                busy_q <= via_dout[7];
            if (state == P_EL && !cpu_en) begin
                if (poll_again)
                    poll_cnt <= poll_cnt + PW'(1);
                else
                    tmo_q <= busy_q;
            end
        end
    end

    assign via_en   = cpu_en | (seq_en & ~rst);
    assign via_we   = cpu_en ? cpu_we  : seq_we;
    assign via_rs   = cpu_en ? cpu_rs  : seq_rs;
    assign via_din  = cpu_en ? cpu_din : seq_din;
    assign cpu_dout = via_dout;

endmodule

// File: tb/tb_via_lcd_ctrl.sv
// Randomized bench for via_lcd_ctrl: VIA read model, CPU contention
// and a step-list reference of each LCD transfer.
module tb_via_lcd_ctrl;

    localparam int H  = 4;
    localparam int PM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_en;
    logic       cpu_we;
    logic [3:0] cpu_rs;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       done;
    logic       timeout;
    logic       via_en;
    logic       via_we;
    logic [3:0] via_rs;
    logic [7:0] via_din;
    logic [7:0] via_dout;

    via_lcd_ctrl #(.E_HOLD(H), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_rs(cpu_rs),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data),
        .done(done), .timeout(timeout),
        .via_en(via_en), .via_we(via_we), .via_rs(via_rs),
        .via_din(via_din), .via_dout(via_dout)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [12:0] tr_q[$];
    logic [12:0] exp_q[$];
    bit          sched[256];
    int          t_m;
    int          busy_left;
    logic [7:0]  rd_next;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock: VIA read data lands after the edge, then inputs, then look
    task automatic clk_cyc(input logic r, input logic v, input logic ce);
        @(posedge clk);
        #1;
        via_dout  = rd_next;
        rst       = r;
        req_valid = v;
        cpu_en    = ce;
        cpu_we    = 1'($urandom);
        cpu_rs    = 4'($urandom);
        cpu_din   = 8'($urandom);
        #1;
        rd_next = via_dout;
        if (cpu_en) begin
            chk("pass", {via_en, via_we, via_rs, via_din},
                {1'b1, cpu_we, cpu_rs, cpu_din});
            chk("cpu_dout", cpu_dout, via_dout);
            if (!cpu_we) rd_next = 8'($urandom);
        end else if (via_en) begin
            tr_q.push_back({via_rs, via_we, via_we ? via_din : 8'h00});
            if (!via_we && via_rs == 4'd0) begin
                rd_next = {busy_left > 0, 7'($urandom)};
                if (busy_left > 0) busy_left--;
            end
        end
    endtask

    task automatic m_acc(input logic [12:0] e);
        exp_q.push_back(e);
        while (sched[t_m] && t_m < 255) t_m++;
        t_m++;
    endtask

    task automatic model(input logic rs, input logic [7:0] d,
                         input int nbusy, output int dcyc,
                         output logic tmo);
        int npoll;
        npoll = (nbusy + 1 < PM) ? nbusy + 1 : PM;
        tmo   = nbusy >= PM;
        exp_q.delete();
        t_m = 1;
        m_acc({4'd2, 1'b1, 8'h00});
        m_acc({4'd1, 1'b1, 8'h40});
        for (int k = 0; k < npoll; k++) begin
            m_acc({4'd1, 1'b1, 8'hC0});
            t_m += H;
            m_acc({4'd0, 1'b0, 8'h00});
            t_m += 1;
            m_acc({4'd1, 1'b1, 8'h40});
        end
        m_acc({4'd2, 1'b1, 8'hFF});
        m_acc({4'd0, 1'b1, d});
        m_acc({4'd1, 1'b1, 2'b00, rs, 5'b0});
        m_acc({4'd1, 1'b1, 2'b10, rs, 5'b0});
        t_m += H;
        m_acc({4'd1, 1'b1, 2'b00, rs, 5'b0});
        dcyc = t_m;
    endtask

    task automatic do_reset(input int len, input int ccyc);
        int dn;
        tr_q.delete();
        for (int i = 0; i < len; i++) clk_cyc(1'b1, 1'b0, 1'b0);
        dn = 0;
        for (int i = 0; i < ccyc + 8; i++) begin
            clk_cyc(1'b0, 1'b0, i < ccyc);
            if (i == 0) begin
                chk("rst_ready", req_ready, 0);
                chk("rst_done", done, 0);
                chk("rst_tmo", timeout, 0);
            end
            if (i == ccyc) chk("init_notready", req_ready, 0);
            if (done) dn++;
        end
        chk("rst_nodone", dn, 0);
        chk("init_len", tr_q.size(), 1);
        if (tr_q.size() > 0) chk("init_acc", tr_q[0], {4'd3, 1'b1, 8'hE0});
        chk("init_ready", req_ready, 1);
    endtask

    task automatic run_xfer(input logic rs, input logic [7:0] d,
                            input int nbusy, input bit rnd,
                            input int s0, input int slen, input int rst_at);
        int   dcyc;
        logic tmo;
        int   w;
        bit   got;
        for (int i = 0; i < 256; i++)
            sched[i] = rnd ? ($urandom_range(0, 4) == 0)
                           : (i >= s0 && i < s0 + slen);
        sched[0] = 1'b0;
        model(rs, d, nbusy, dcyc, tmo);
        busy_left = nbusy;
        req_rs    = rs;
        req_data  = d;
        tr_q.delete();
        w = 0;
        do begin
            clk_cyc(1'b0, 1'b1, 1'b0);
            w++;
        end while (!req_ready && w < 50);
        if (!req_ready) begin
            chk("ready_wait", req_ready, 1);
            return;
        end
        got = 1'b0;
        for (int n = 1; n <= dcyc + 8 && !got; n++) begin
            if (n == rst_at) begin
                do_reset(1, 2);
                return;
            end
            clk_cyc(1'b0, 1'b0, sched[n]);
            if (n == 1) chk("busy_ready", req_ready, 0);
            if (done) begin
                got = 1'b1;
                chk("done_cyc", n, dcyc);
                chk("timeout", timeout, tmo);
                chk("tr_len", tr_q.size(), exp_q.size());
                for (int i = 0; i < tr_q.size() && i < exp_q.size(); i++)
                    chk($sformatf("tr%0d", i), tr_q[i], exp_q[i]);
            end
        end
        if (!got) begin
            chk("done_seen", 0, 1);
        end else begin
            clk_cyc(1'b0, 1'b0, 1'b0);
            chk("done_pulse", done, 0);
            chk("ready_after", req_ready, 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cpu_en    = 1'b0;
        cpu_we    = 1'b0;
        cpu_rs    = 4'd0;
        cpu_din   = 8'd0;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'd0;
        via_dout  = 8'd0;
        rd_next   = 8'd0;
        busy_left = 0;

        do_reset(3, 2);
        run_xfer(1'b0, 8'h38, 0, 1'b0, 0, 0, -1);
        run_xfer(1'b1, 8'h41, 2, 1'b0, 0, 0, -1);
        run_xfer(1'b0, 8'h01, 99, 1'b0, 0, 0, -1);
        run_xfer(1'b1, 8'h55, 0, 1'b0, 8 + H, 5, -1);
        run_xfer(1'b0, 8'h0C, 0, 1'b0, 0, 0, 12 + H);
        run_xfer(1'b1, 8'h42, 1, 1'b0, 0, 0, -1);
        for (int k = 0; k < 12; k++)
            run_xfer(1'($urandom), 8'($urandom), $urandom_range(0, 4),
                     1'b1, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
